// File: rtl/kernel_bc_start_arbiter.sv
// Round-robin arbiter that issues one start token per cycle into a downstream start FIFO.
// It bounds the number of granted-but-unretired tokens with a credit counter.
module kernel_bc_start_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 1,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_WIDTH    = 4,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full_n,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          done_pulse,
  output logic [CNT_WIDTH-1:0]          inflight,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          err_underflow
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]    inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]   fifo_din_q, fifo_din_d;
  logic [IDX_W-1:0]        grant_id_q, grant_id_d;
  logic                    err_underflow_q, err_underflow_d;

  logic [DATA_WIDTH-1:0]   req_slice [NUM_REQ];
  logic                    grant_found;
  logic [IDX_W-1:0]        grant_idx;
  logic                    eligible;
  logic                    grant;
  logic                    retire;
  logic [NUM_REQ-1:0]      grant_vec;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign req_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search upward from rr_ptr with wrap-around; the first valid requester wins.
  always_comb begin
    int cand_sum;
    logic [IDX_W-1:0] cand;
    // NOTE: every variable written in a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = 0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = int'(rr_ptr_q) + k;
      if (cand_sum >= NUM_REQ) cand_sum = cand_sum - NUM_REQ;
      cand = IDX_W'(cand_sum);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A held token only frees its slot when the FIFO accepts it this cycle.
  assign eligible = enable && grant_found && (inflight_q < MAX_CNT) &&
                    ((state_q == IDLE) || fifo_full_n);
  assign grant    = eligible;
  assign retire   = done_pulse && (inflight_q != '0);

  always_comb begin
    grant_vec = '0;
    if (grant) grant_vec[grant_idx] = 1'b1;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      inflight_q      <= '0;
      fifo_din_q      <= '0;
      grant_id_q      <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      inflight_q      <= inflight_d;
      fifo_din_q      <= fifo_din_d;
      grant_id_q      <= grant_id_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    fifo_din_d      = fifo_din_q;
    grant_id_d      = grant_id_q;
    inflight_d      = inflight_q;
    err_underflow_d = err_underflow_q || (done_pulse && (inflight_q == '0));

    if (grant) begin
      state_d    = ISSUE;
      fifo_din_d = req_slice[grant_idx];
      grant_id_d = grant_idx;
      rr_ptr_d   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == ISSUE) && fifo_full_n) begin
      state_d = IDLE;
    end

    unique case ({grant, retire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Output logic; req_ready is forced low while reset is asserted.
  always_comb begin
    req_ready     = reset_n ? grant_vec : '0;
    fifo_write    = (state_q == ISSUE);
    fifo_din      = fifo_din_q;
    grant_id      = grant_id_q;
    inflight      = inflight_q;
    err_underflow = err_underflow_q;
  end

endmodule
